// File: rtl/spi_burst_pkg.sv
// Shared opcodes, FSM state encoding and status bit positions for the SPI burst register file.
package spi_burst_pkg;

    localparam int unsigned CMD_W = 8;

    localparam logic [CMD_W-1:0] CMD_WRITE  = 8'h02;
    localparam logic [CMD_W-1:0] CMD_READ   = 8'h03;
    localparam logic [CMD_W-1:0] CMD_STATUS = 8'h05;

    localparam int unsigned STAT_EN       = 0;
    localparam int unsigned STAT_BAD_CMD  = 1;
    localparam int unsigned STAT_ADDR_OOR = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_STAT,
        ST_DROP
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI/enable pins into the system clock and flags
// sclk and ss_n edges on the synchronised copies.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_ss_n,
    input  logic i_mosi,
    input  logic i_enable_n,
    output logic o_mosi,
    output logic o_enable_n,
    output logic o_sclk_rise_c,
    output logic o_sclk_fall_c,
    output logic o_ss_fall_c,
    output logic o_ss_rise_c
);

    // ss_n resets low so a pin already low at reset release never looks like a frame start.
    localparam logic [3:0] RST_VAL = 4'b1000;

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic                        r_sclk_d;
    logic                        r_ss_n_d;
    logic [3:0]                  w_in;
    logic [3:0]                  w_out;

    assign w_in  = {i_enable_n, i_ss_n, i_mosi, i_sclk};
    assign w_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= {SYNC_STAGES{RST_VAL}};
            r_sclk_d <= 1'b0;
            r_ss_n_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], w_in};
            r_sclk_d <= w_out[0];
            r_ss_n_d <= w_out[2];
        end
    end

    assign o_mosi        = w_out[1];
    assign o_enable_n    = w_out[3];
    assign o_sclk_rise_c = w_out[0] & ~r_sclk_d;
    assign o_sclk_fall_c = ~w_out[0] & r_sclk_d;
    assign o_ss_fall_c   = ~w_out[2] & r_ss_n_d;
    assign o_ss_rise_c   = w_out[2] & ~r_ss_n_d;

endmodule

// File: rtl/spi_burst_regfile.sv
// SPI-slave register file with burst write/read, sticky status and a registered
// core-side read port; SPI pins are oversampled in the wb_clk_i domain.
module spi_burst_regfile
    import spi_burst_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              enable_n,
    input  logic              ss_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [ADDR_W-1:0] core_addr,
    output logic [DATA_W-1:0] core_rdata,
    output logic              wr_strobe,
    output logic              frame_active
);

    localparam int unsigned FIELD_MAX = max3(CMD_W, ADDR_W, DATA_W);
    localparam int unsigned SH_W      = FIELD_MAX - 1;
    localparam int unsigned TX_W      = (DATA_W > CMD_W) ? DATA_W : CMD_W;
    localparam int unsigned CNT_W     = $clog2(FIELD_MAX);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_e            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [SH_W-1:0]   r_shift;
    logic [TX_W-1:0]   r_tx;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_is_read;
    logic              r_reload;
    logic              r_bad_cmd;
    logic              r_addr_oor;

    logic              w_mosi;
    logic              w_enable_n;
    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_ss_fall;
    logic              w_ss_rise;
    logic [CMD_W-1:0]  w_cmd_byte;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_rd_word;
    logic [ADDR_W-1:0] w_ptr_next;
    logic [CMD_W-1:0]  w_stat;
    logic [TX_W-1:0]   w_tx_word;
    logic [TX_W-1:0]   w_tx_stat;
    logic              w_addr_ok;
    logic              w_ptr_ok;
    logic              w_core_ok;
    logic              w_last_data;
    logic              w_wr_en;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk         (wb_clk_i),
        .i_rst         (wb_rst_i),
        .i_sclk        (sclk),
        .i_ss_n        (ss_n),
        .i_mosi        (mosi),
        .i_enable_n    (enable_n),
        .o_mosi        (w_mosi),
        .o_enable_n    (w_enable_n),
        .o_sclk_rise_c (w_sclk_rise),
        .o_sclk_fall_c (w_sclk_fall),
        .o_ss_fall_c   (w_ss_fall),
        .o_ss_rise_c   (w_ss_rise)
    );

    // Fields complete on the rise that samples their last bit, so include the live mosi.
    assign w_cmd_byte  = {r_shift[CMD_W-2:0], w_mosi};
    assign w_addr      = {r_shift[ADDR_W-2:0], w_mosi};
    assign w_word      = {r_shift[DATA_W-2:0], w_mosi};
    assign w_addr_ok   = {1'b0, w_addr} < DEPTH_L;
    assign w_ptr_ok    = {1'b0, r_ptr} < DEPTH_L;
    assign w_core_ok   = {1'b0, core_addr} < DEPTH_L;
    assign w_ptr_next  = ({1'b0, r_ptr} >= (DEPTH_L - 1'b1)) ? '0 : r_ptr + 1'b1;
    assign w_rd_word   = w_ptr_ok ? r_mem[r_ptr] : '0;
    assign w_tx_word   = TX_W'(w_rd_word) << (TX_W - DATA_W);
    assign w_tx_stat   = TX_W'(w_stat) << (TX_W - CMD_W);
    assign w_last_data = (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_wr_en     = (r_state == ST_WDATA) && w_sclk_rise && w_last_data && w_ptr_ok
                         && !w_enable_n && !w_ss_rise;

    always_comb begin
        w_stat                = '0;
        w_stat[STAT_EN]       = ~w_enable_n;
        w_stat[STAT_BAD_CMD]  = r_bad_cmd;
        w_stat[STAT_ADDR_OOR] = r_addr_oor;
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_wr_en) r_mem[r_ptr] <= w_word;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) core_rdata <= '0;
        else          core_rdata <= w_core_ok ? r_mem[core_addr] : '0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_tx         <= '0;
            r_ptr        <= '0;
            r_is_read    <= 1'b0;
            r_reload     <= 1'b0;
            r_bad_cmd    <= 1'b0;
            r_addr_oor   <= 1'b0;
            miso         <= 1'b0;
            miso_oe      <= 1'b0;
            frame_active <= 1'b0;
            wr_strobe    <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            r_reload  <= 1'b0;
            // Pointer was advanced last cycle; fetch its word well before the next sclk fall.
            if (r_reload) r_tx <= w_tx_word;
            if (w_ss_rise) begin
                r_state      <= ST_IDLE;
                miso         <= 1'b0;
                miso_oe      <= 1'b0;
                frame_active <= 1'b0;
            end else if (r_state != ST_IDLE && r_state != ST_DROP && w_enable_n) begin
                r_state <= ST_DROP;
                miso    <= 1'b0;
            end else begin
                if (w_sclk_rise) r_shift <= {r_shift[SH_W-2:0], w_mosi};
                case (r_state)
                    ST_IDLE: begin
                        if (w_ss_fall && !w_enable_n) begin
                            r_state      <= ST_CMD;
                            r_bit_cnt    <= '0;
                            miso         <= 1'b0;
                            miso_oe      <= 1'b1;
                            frame_active <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == CNT_W'(CMD_W - 1)) begin
                                r_bit_cnt <= '0;
                                case (w_cmd_byte)
                                    CMD_WRITE, CMD_READ: begin
                                        r_state   <= ST_ADDR;
                                        r_is_read <= (w_cmd_byte == CMD_READ);
                                    end
                                    CMD_STATUS: begin
                                        r_state <= ST_STAT;
                                        r_tx    <= w_tx_stat;
                                    end
                                    default: begin
                                        r_state   <= ST_DROP;
                                        r_bad_cmd <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == CNT_W'(ADDR_W - 1)) begin
                                r_bit_cnt <= '0;
                                r_ptr     <= w_addr;
                                if (!w_addr_ok) r_addr_oor <= 1'b1;
                                r_state   <= r_is_read ? ST_RDATA : ST_WDATA;
                                r_reload  <= r_is_read;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_last_data) begin
                                r_bit_cnt <= '0;
                                r_ptr     <= w_ptr_next;
                                wr_strobe <= w_wr_en;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (w_last_data) begin
                                r_bit_cnt <= '0;
                                r_ptr     <= w_ptr_next;
                                r_reload  <= 1'b1;
                            end
                        end
                        if (w_sclk_fall) begin
                            miso <= r_tx[TX_W-1];
                            r_tx <= {r_tx[TX_W-2:0], 1'b0};
                        end
                    end
                    ST_STAT: begin
                        // Sticky bits clear once the master has sampled the final status bit.
                        if (w_sclk_rise) begin
                            if (r_bit_cnt == CNT_W'(CMD_W - 1)) begin
                                r_bad_cmd  <= 1'b0;
                                r_addr_oor <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                        if (w_sclk_fall) begin
                            miso <= r_tx[TX_W-1];
                            r_tx <= {r_tx[TX_W-2:0], 1'b0};
                        end
                    end
                    ST_DROP: miso <= 1'b0;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_regfile.sv
// Self-checking bench: two instances (DEPTH 256 and 200) share the SPI pins and are
// compared against a word-level model of memory, burst pointers and sticky status.
module tb_spi_burst_regfile;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable_n = 1'b0;
    logic       ss_n = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic [7:0] core_addr = 8'h00;

    logic        miso0, oe0, ws0, fa0;
    logic        miso1, oe1, ws1, fa1;
    logic [15:0] crd0, crd1;

    always #5 clk = ~clk;

    spi_burst_regfile u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_n(enable_n), .ss_n(ss_n), .sclk(sclk),
        .mosi(mosi), .miso(miso0), .miso_oe(oe0), .core_addr(core_addr),
        .core_rdata(crd0), .wr_strobe(ws0), .frame_active(fa0)
    );

    spi_burst_regfile #(.DEPTH(200)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_n(enable_n), .ss_n(ss_n), .sclk(sclk),
        .mosi(mosi), .miso(miso1), .miso_oe(oe1), .core_addr(core_addr),
        .core_rdata(crd1), .wr_strobe(ws1), .frame_active(fa1)
    );

    int n_chk = 0;
    int n_pass = 0;
    int sc0 = 0;
    int sc1 = 0;

    logic [15:0] tx_words [8];
    logic [15:0] rx [2][8];
    logic [7:0]  stat_rx [2];
    logic        oe_s [2];
    logic        fa_s [2];
    int          sd [2];

    // Reference model state.
    logic [15:0] mm [2][256];
    bit          mv [2][256];
    int          dep [2];
    bit          st_oor [2];
    bit          st_bad [2];
    int          exp_sd [2];
    logic [15:0] exp_rx [2][8];
    bit          exp_ok [2][8];

    always @(posedge clk) begin
        if (ws0 === 1'b1) sc0++;
        if (ws1 === 1'b1) sc1++;
    end

    function automatic int nxt(input int k, input int p);
        return (p >= dep[k] - 1) ? 0 : p + 1;
    endfunction

    task automatic xfer(input logic [15:0] d, input int n,
                        output logic [15:0] r0, output logic [15:0] r1);
        r0 = '0;
        r1 = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = d[i];
            repeat (5) @(posedge clk);
            #1;
            r0[i] = miso0;
            r1[i] = miso1;
            sclk = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int addr, input int nw,
                             input int abort_bits);
        logic [15:0] a, b;
        int b0, b1;
        b0 = sc0;
        b1 = sc1;
        ss_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        xfer(16'(cmd), 8, a, b);
        oe_s[0] = oe0; oe_s[1] = oe1;
        fa_s[0] = fa0; fa_s[1] = fa1;
        if (cmd == 8'h02 || cmd == 8'h03) xfer(16'(addr), 8, a, b);
        if (cmd == 8'h05) begin
            xfer(16'h0000, 8, a, b);
            stat_rx[0] = a[7:0];
            stat_rx[1] = b[7:0];
        end
        for (int w = 0; w < nw; w++) begin
            if (abort_bits >= 0 && w == nw - 1)
                xfer(tx_words[w] >> (16 - abort_bits), abort_bits, a, b);
            else
                xfer(tx_words[w], 16, a, b);
            rx[0][w] = a;
            rx[1][w] = b;
        end
        repeat (6) @(posedge clk);
        #1;
        ss_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        sd[0] = sc0 - b0;
        sd[1] = sc1 - b1;
    endtask

    task automatic model_frame(input logic [7:0] cmd, input int addr, input int nfull);
        int p;
        for (int k = 0; k < 2; k++) begin
            exp_sd[k] = 0;
            if (cmd == 8'h02 || cmd == 8'h03) begin
                if (addr >= dep[k]) st_oor[k] = 1'b1;
                if (cmd == 8'h02) begin
                    p = addr;
                    for (int w = 0; w < nfull; w++) begin
                        if (p < dep[k]) begin
                            mm[k][p] = tx_words[w];
                            mv[k][p] = 1'b1;
                            exp_sd[k]++;
                        end
                        p = nxt(k, p);
                    end
                end
            end else if (cmd != 8'h05) begin
                st_bad[k] = 1'b1;
            end
        end
    endtask

    task automatic spi_write(input int addr, input int nw);
        spi_frame(8'h02, addr, nw, -1);
        model_frame(8'h02, addr, nw);
    endtask

    task automatic spi_read(input int addr, input int nw);
        int p;
        spi_frame(8'h03, addr, nw, -1);
        model_frame(8'h03, addr, 0);
        for (int k = 0; k < 2; k++) begin
            p = addr;
            for (int w = 0; w < nw; w++) begin
                exp_ok[k][w] = (p >= dep[k]) || mv[k][p];
                exp_rx[k][w] = (p < dep[k]) ? mm[k][p] : 16'h0000;
                p = nxt(k, p);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({miso0, oe0, ws0, fa0, crd0} !== 20'h0)
            $display("FAIL reset inst0: got %h want 0", {miso0, oe0, ws0, fa0, crd0});
        else n_pass++;
        n_chk++;
        if ({miso1, oe1, ws1, fa1, crd1} !== 20'h0)
            $display("FAIL reset inst1: got %h want 0", {miso1, oe1, ws1, fa1, crd1});
        else n_pass++;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        tx_words[0] = 16'hFACE;
        spi_write(0, 1);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (sd[k] !== exp_sd[k])
                $display("FAIL single_strobe inst%0d: got %0d want %0d", k, sd[k], exp_sd[k]);
            else n_pass++;
            n_chk++;
            if ({oe_s[k], fa_s[k]} !== 2'b11)
                $display("FAIL single_oe_fa inst%0d: got %b want 11", k, {oe_s[k], fa_s[k]});
            else n_pass++;
        end
        n_chk++;
        if ({oe0, fa0, oe1, fa1} !== 4'b0000)
            $display("FAIL post_frame_oe: got %b want 0000", {oe0, fa0, oe1, fa1});
        else n_pass++;
        spi_read(0, 1);
        for (int k = 0; k < 2; k++) begin
            if (exp_ok[k][0]) begin
                n_chk++;
                if (rx[k][0] !== exp_rx[k][0])
                    $display("FAIL single_read inst%0d: got %h want %h", k, rx[k][0], exp_rx[k][0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_burst_wrap;
        tx_words[0] = 16'hDEAD;
        tx_words[1] = 16'hBEEF;
        tx_words[2] = 16'hAAAA;
        spi_write(8'hFE, 3);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (sd[k] !== exp_sd[k])
                $display("FAIL burst_strobe inst%0d: got %0d want %0d", k, sd[k], exp_sd[k]);
            else n_pass++;
        end
        spi_read(8'hFE, 3);
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 3; w++)
                if (exp_ok[k][w]) begin
                    n_chk++;
                    if (rx[k][w] !== exp_rx[k][w])
                        $display("FAIL burst_read inst%0d w%0d: got %h want %h",
                                 k, w, rx[k][w], exp_rx[k][w]);
                    else n_pass++;
                end
    endtask

    task automatic test_abort;
        tx_words[0] = 16'h1111;
        spi_write(5, 1);
        tx_words[0] = 16'h5555;
        spi_frame(8'h02, 5, 1, 9);
        model_frame(8'h02, 5, 0);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (sd[k] !== 0)
                $display("FAIL abort_strobe inst%0d: got %0d want 0", k, sd[k]);
            else n_pass++;
        end
        spi_read(5, 1);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (rx[k][0] !== exp_rx[k][0])
                $display("FAIL abort_read inst%0d: got %h want %h", k, rx[k][0], exp_rx[k][0]);
            else n_pass++;
        end
    endtask

    task automatic test_bad_status;
        logic [7:0] e;
        spi_frame(8'h7E, 0, 0, -1);
        model_frame(8'h7E, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (sd[k] !== 0)
                $display("FAIL badcmd_strobe inst%0d: got %0d want 0", k, sd[k]);
            else n_pass++;
        end
        for (int rep = 0; rep < 2; rep++) begin
            spi_frame(8'h05, 0, 0, -1);
            for (int k = 0; k < 2; k++) begin
                e = {5'b0, st_oor[k], st_bad[k], 1'b1};
                n_chk++;
                if (stat_rx[k] !== e)
                    $display("FAIL status%0d inst%0d: got %b want %b", rep, k, stat_rx[k], e);
                else n_pass++;
                st_oor[k] = 1'b0;
                st_bad[k] = 1'b0;
            end
        end
    endtask

    task automatic test_oor;
        logic [7:0] e;
        tx_words[0] = 16'h1234;
        spi_write(8'hC8, 1);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (sd[k] !== exp_sd[k])
                $display("FAIL oor_strobe inst%0d: got %0d want %0d", k, sd[k], exp_sd[k]);
            else n_pass++;
        end
        spi_read(8'hC8, 1);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (rx[k][0] !== exp_rx[k][0])
                $display("FAIL oor_read inst%0d: got %h want %h", k, rx[k][0], exp_rx[k][0]);
            else n_pass++;
        end
        spi_frame(8'h05, 0, 0, -1);
        for (int k = 0; k < 2; k++) begin
            e = {5'b0, st_oor[k], st_bad[k], 1'b1};
            n_chk++;
            if (stat_rx[k] !== e)
                $display("FAIL oor_status inst%0d: got %b want %b", k, stat_rx[k], e);
            else n_pass++;
            st_oor[k] = 1'b0;
            st_bad[k] = 1'b0;
        end
    endtask

    task automatic test_enable_core;
        logic [7:0]  alist [4];
        logic [15:0] e, got;
        int          a;
        tx_words[0] = 16'h0101;
        spi_write(1, 1);
        enable_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        tx_words[0] = 16'hDADE;
        spi_frame(8'h02, 1, 1, -1);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if ({oe_s[k], fa_s[k], 8'(sd[k])} !== 10'h0)
                $display("FAIL disabled inst%0d: oe/fa/strobes got %b/%b/%0d want 0/0/0",
                         k, oe_s[k], fa_s[k], sd[k]);
            else n_pass++;
        end
        enable_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        spi_read(1, 1);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (rx[k][0] !== exp_rx[k][0])
                $display("FAIL disabled_read inst%0d: got %h want %h", k, rx[k][0], exp_rx[k][0]);
            else n_pass++;
        end
        alist[0] = 8'h00; alist[1] = 8'hC8; alist[2] = 8'hFF; alist[3] = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            core_addr = alist[i];
            @(posedge clk);
            #1;
            a = int'(alist[i]);
            for (int k = 0; k < 2; k++) begin
                if (a >= dep[k] || mv[k][a]) begin
                    e = (a < dep[k]) ? mm[k][a] : 16'h0000;
                    got = (k == 0) ? crd0 : crd1;
                    n_chk++;
                    if (got !== e)
                        $display("FAIL core_rd inst%0d addr %h: got %h want %h", k, alist[i], got, e);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] a, b;
        int b0, b1;
        tx_words[0] = 16'h2222;
        spi_write(8'h10, 1);
        b0 = sc0;
        b1 = sc1;
        ss_n = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        xfer(16'h0002, 8, a, b);
        xfer(16'h0010, 8, a, b);
        xfer(16'h0033, 8, a, b);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({miso0, oe0, ws0, fa0, crd0, miso1, oe1, ws1, fa1, crd1} !== 40'h0)
            $display("FAIL midreset_outputs: got %h want 0",
                     {miso0, oe0, ws0, fa0, crd0, miso1, oe1, ws1, fa1, crd1});
        else n_pass++;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        xfer(16'h0033, 8, a, b);
        repeat (6) @(posedge clk);
        #1;
        ss_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_chk++;
        if ((sc0 - b0) !== 0 || (sc1 - b1) !== 0)
            $display("FAIL midreset_strobe: got %0d/%0d want 0/0", sc0 - b0, sc1 - b1);
        else n_pass++;
        spi_read(8'h10, 1);
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (rx[k][0] !== exp_rx[k][0])
                $display("FAIL midreset_read inst%0d: got %h want %h", k, rx[k][0], exp_rx[k][0]);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        int addr, nw;
        for (int it = 0; it < 6; it++) begin
            addr = $urandom_range(0, 255);
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) tx_words[w] = 16'($urandom);
            spi_write(addr, nw);
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (sd[k] !== exp_sd[k])
                    $display("FAIL rand%0d_strobe inst%0d: got %0d want %0d", it, k, sd[k], exp_sd[k]);
                else n_pass++;
            end
            spi_read(addr, nw);
            for (int k = 0; k < 2; k++)
                for (int w = 0; w < nw; w++)
                    if (exp_ok[k][w]) begin
                        n_chk++;
                        if (rx[k][w] !== exp_rx[k][w])
                            $display("FAIL rand%0d_read inst%0d w%0d: got %h want %h",
                                     it, k, w, rx[k][w], exp_rx[k][w]);
                        else n_pass++;
                    end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        dep[0] = 256;
        dep[1] = 200;
        for (int k = 0; k < 2; k++) begin
            st_oor[k] = 1'b0;
            st_bad[k] = 1'b0;
        end
        test_reset;
        test_single;
        test_burst_wrap;
        test_abort;
        test_bad_status;
        test_oor;
        test_enable_core;
        test_reset_midframe;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
